// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply sequencer and its MAC datapath.
package matmul_pkg;

  localparam int MAX_DIM_DEF = 4;
  localparam int DATA_W_DEF  = 16;
  localparam int ACC_W_DEF   = 32;
  // Read-to-accumulate latency; the DRAIN1/DRAIN2 states cover exactly this many cycles.
  localparam int PIPE_LAT    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN1,
    ST_DRAIN2,
    ST_WRITE
  } state_t;

  // Packs {row,col} with col occupying the low col_w bits; callers truncate to their address width.
  function automatic logic [31:0] pack_addr(input logic [15:0] row, input logic [15:0] col,
                                            input int col_w);
    return ({16'd0, row} << col_w) | {16'd0, col};
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Two-stage multiply-accumulate: stage 1 registers the operand pair, stage 2 adds the product.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              in_valid,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic [ACC_W-1:0]  acc
);

  logic [DATA_W-1:0]   a_q_reg;
  logic [DATA_W-1:0]   b_q_reg;
  logic                prod_valid_reg;
  logic [ACC_W-1:0]    acc_reg;
  logic [2*DATA_W-1:0] prod;

  assign prod = {{DATA_W{1'b0}}, a_q_reg} * {{DATA_W{1'b0}}, b_q_reg};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      a_q_reg        <= '0;
      b_q_reg        <= '0;
      prod_valid_reg <= 1'b0;
      acc_reg        <= '0;
    end else begin
      prod_valid_reg <= in_valid;
      if (in_valid) begin
        a_q_reg <= a_data;
        b_q_reg <= b_data;
      end
      // The pipeline is empty on the first RUN cycle, so clear never collides with a valid product.
      if (clr)
        acc_reg <= '0;
      else if (prod_valid_reg)
        acc_reg <= acc_reg + ACC_W'(prod);
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/matmul_sequencer.sv
// Job FSM, i/j/k index counters, operand/result address generation and status flags.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int MAX_DIM = MAX_DIM_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int IDX_W   = $clog2(MAX_DIM)
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                start,
  input  logic                abort,
  input  logic [IDX_W:0]      dim_n,
  output logic                a_rd_en,
  output logic [2*IDX_W-1:0]  a_addr,
  input  logic [DATA_W-1:0]   a_rdata,
  output logic                b_rd_en,
  output logic [2*IDX_W-1:0]  b_addr,
  input  logic [DATA_W-1:0]   b_rdata,
  output logic                c_wr_en,
  output logic [2*IDX_W-1:0]  c_addr,
  output logic [ACC_W-1:0]    c_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                irq,
  output logic [31:0]         cycle_count
);

  localparam int ADDR_W = 2 * IDX_W;
  localparam logic [IDX_W:0] MAX_N = (IDX_W + 1)'(MAX_DIM);

  state_t             state_reg, state_next;
  logic [IDX_W:0]     n_reg;
  logic [IDX_W-1:0]   i_reg, j_reg, k_reg;
  logic [IDX_W-1:0]   last_idx;
  logic               done_reg, err_reg, irq_reg;
  logic [31:0]        cycle_count_reg;
  logic               rd_valid_reg;
  logic               mac_clr;
  logic               dim_ok;
  logic               last_elem;
  logic [ACC_W-1:0]   acc;

  assign last_idx  = IDX_W'(n_reg - 1'b1);
  assign dim_ok    = (dim_n != '0) && (dim_n <= MAX_N);
  assign last_elem = (i_reg == last_idx) && (j_reg == last_idx);

  matmul_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .in_valid (rd_valid_reg),
    .clr      (mac_clr),
    .a_data   (a_rdata),
    .b_data   (b_rdata),
    .acc      (acc)
  );

  always_comb begin
    state_next = state_reg;
    a_rd_en    = 1'b0;
    b_rd_en    = 1'b0;
    c_wr_en    = 1'b0;
    a_addr     = '0;
    b_addr     = '0;
    c_addr     = '0;
    c_wdata    = '0;
    mac_clr    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start && !abort && dim_ok)
          state_next = ST_RUN;
      end
      ST_RUN: begin
        a_rd_en = 1'b1;
        b_rd_en = 1'b1;
        a_addr  = ADDR_W'(pack_addr(16'(i_reg), 16'(k_reg), IDX_W));
        b_addr  = ADDR_W'(pack_addr(16'(k_reg), 16'(j_reg), IDX_W));
        mac_clr = (k_reg == '0);
        if (k_reg == last_idx)
          state_next = ST_DRAIN1;
      end
      ST_DRAIN1: state_next = ST_DRAIN2;
      ST_DRAIN2: state_next = ST_WRITE;
      ST_WRITE: begin
        c_wr_en    = 1'b1;
        c_addr     = ADDR_W'(pack_addr(16'(i_reg), 16'(j_reg), IDX_W));
        c_wdata    = acc;
        state_next = last_elem ? ST_IDLE : ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort && state_reg != ST_IDLE)
      state_next = ST_IDLE;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg       <= ST_IDLE;
      n_reg           <= '0;
      i_reg           <= '0;
      j_reg           <= '0;
      k_reg           <= '0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      irq_reg         <= 1'b0;
      cycle_count_reg <= '0;
      rd_valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      irq_reg      <= 1'b0;
      rd_valid_reg <= a_rd_en;
      if (state_reg == ST_IDLE) begin
        if (start && !abort) begin
          if (dim_ok) begin
            n_reg           <= dim_n;
            i_reg           <= '0;
            j_reg           <= '0;
            k_reg           <= '0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            cycle_count_reg <= '0;
          end else begin
            err_reg <= 1'b1;
          end
        end
      end else begin
        if (cycle_count_reg != '1)
          cycle_count_reg <= cycle_count_reg + 32'd1;
        // An aborted job freezes its indices; the next accepted start reloads them.
        if (!abort) begin
          if (state_reg == ST_RUN)
            k_reg <= (k_reg == last_idx) ? '0 : k_reg + 1'b1;
          if (state_reg == ST_WRITE) begin
            if (j_reg == last_idx) begin
              j_reg <= '0;
              if (i_reg == last_idx) begin
                i_reg    <= '0;
                done_reg <= 1'b1;
                irq_reg  <= 1'b1;
              end else begin
                i_reg <= i_reg + 1'b1;
              end
            end else begin
              j_reg <= j_reg + 1'b1;
            end
          end
        end
      end
    end
  end

  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_reg;
  assign err         = err_reg;
  assign irq         = irq_reg;
  assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench: synchronous operand memories, C-write capture and a plain-arithmetic product model.
module tb_matmul_sequencer;

  localparam int MD = 4;
  localparam int IW = 2;

  logic        ACLK;
  logic        ARESET;
  logic        start;
  logic        abort;
  logic [IW:0] dim_n;
  logic        a_rd_en, b_rd_en, c_wr_en;
  logic [3:0]  a_addr, b_addr, c_addr;
  logic [15:0] a_rdata, b_rdata;
  logic [31:0] c_wdata;
  logic        busy, done, err, irq;
  logic [31:0] cycle_count;

  matmul_sequencer #(.MAX_DIM(MD), .DATA_W(16), .ACC_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort), .dim_n(dim_n),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
    .c_wr_en(c_wr_en), .c_addr(c_addr), .c_wdata(c_wdata),
    .busy(busy), .done(done), .err(err), .irq(irq), .cycle_count(cycle_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int dim;
    bit exp_ok;
    int exp_busy;
  } vec_t;

  logic [15:0] a_mem [MD*MD];
  logic [15:0] b_mem [MD*MD];
  wr_t         wr_q [$];
  int          busy_cnt = 0, irq_cnt = 0, rd_cnt = 0, oob_cnt = 0;
  int          cur_n = 1;
  logic        pend_a = 1'b0, pend_b = 1'b0;
  logic [3:0]  pend_a_addr = '0, pend_b_addr = '0;
  int          total = 0;
  int          bad = 0;

  // Memory responder and monitor: data for a read strobe seen in cycle t appears during t+1.
  always @(negedge ACLK) begin
    if (pend_a) a_rdata = a_mem[pend_a_addr];
    if (pend_b) b_rdata = b_mem[pend_b_addr];
    pend_a = a_rd_en; pend_a_addr = a_addr;
    pend_b = b_rd_en; pend_b_addr = b_addr;
    if (c_wr_en) wr_q.push_back('{addr: c_addr, data: c_wdata});
    if (busy) busy_cnt++;
    if (irq) irq_cnt++;
    if (a_rd_en || b_rd_en) rd_cnt++;
    if (a_rd_en && (int'(a_addr[3:2]) >= cur_n || int'(a_addr[1:0]) >= cur_n)) oob_cnt++;
    if (b_rd_en && (int'(b_addr[3:2]) >= cur_n || int'(b_addr[1:0]) >= cur_n)) oob_cnt++;
    if (c_wr_en && (int'(c_addr[3:2]) >= cur_n || int'(c_addr[1:0]) >= cur_n)) oob_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_c(input int n, input int i, input int j);
    logic [31:0] s = 0;
    for (int k = 0; k < n; k++)
      s += 32'(a_mem[i*MD+k]) * 32'(b_mem[k*MD+j]);
    return s;
  endfunction

  task automatic fill_random();
    for (int x = 0; x < MD*MD; x++) begin
      a_mem[x] = 16'($urandom);
      b_mem[x] = 16'($urandom);
    end
  endtask

  // Starts a job, optionally re-pulses start at poke_cyc, and checks the finished job against the model.
  task automatic run_job(input int d, input bit exp_ok, input int exp_busy, input int poke_cyc);
    int b_busy, b_irq, b_rd, b_oob, b_wr, cyc, nw;
    @(posedge ACLK);
    b_busy = busy_cnt; b_irq = irq_cnt; b_rd = rd_cnt; b_oob = oob_cnt; b_wr = wr_q.size();
    @(negedge ACLK);
    start = 1'b1; dim_n = 3'(d);
    if (exp_ok) cur_n = d;
    @(negedge ACLK);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 2000) begin
      start = (cyc == poke_cyc);
      if (start) dim_n = 3'd2;
      @(negedge ACLK);
      cyc++;
    end
    start = 1'b0;
    check("job_timeout", 32'(cyc < 2000), 32'd1);
    @(posedge ACLK);
    nw = wr_q.size() - b_wr;
    check("busy_cycles", 32'(busy_cnt - b_busy), 32'(exp_busy));
    check("err_flag", 32'(err), 32'(!exp_ok));
    if (exp_ok) begin
      check("cycle_count", cycle_count, 32'(exp_busy));
      check("done_flag", 32'(done), 32'd1);
      check("irq_pulses", 32'(irq_cnt - b_irq), 32'd1);
      check("write_count", 32'(nw), 32'(d*d));
      check("addr_range", 32'(oob_cnt - b_oob), 32'd0);
      for (int e = 0; e < d*d && e < nw; e++) begin
        check("c_addr", 32'(wr_q[b_wr+e].addr), 32'((e/d)*MD + e%d));
        check("c_data", wr_q[b_wr+e].data, model_c(d, e/d, e%d));
      end
    end else begin
      check("bad_dim_reads", 32'(rd_cnt - b_rd), 32'd0);
      check("bad_dim_writes", 32'(nw), 32'd0);
    end
    $display("job dim=%0d cycles=%0d writes=%0d err=%0b done=%0b", d, busy_cnt - b_busy, nw, err, done);
  endtask

  // Interrupts an n=4 job on busy cycle 'at' with either abort or ARESET.
  task automatic cut_job(input int at, input bit use_reset);
    int b_wr, b_irq, w_after;
    @(posedge ACLK);
    b_wr = wr_q.size(); b_irq = irq_cnt;
    @(negedge ACLK);
    start = 1'b1; dim_n = 3'd4; cur_n = 4;
    @(negedge ACLK);
    start = 1'b0;
    repeat (at - 1) @(negedge ACLK);
    if (use_reset) ARESET = 1'b1; else abort = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0; abort = 1'b0;
    check("cut_busy", 32'(busy), 32'd0);
    check("cut_no_wr", 32'(c_wr_en), 32'd0);
    check("cut_done", 32'(done), 32'd0);
    @(posedge ACLK);
    check("cut_writes", 32'(wr_q.size() - b_wr), 32'(at / 7));
    check("cut_irq", 32'(irq_cnt - b_irq), 32'd0);
    check("cut_cycle_count", cycle_count, use_reset ? 32'd0 : 32'(at));
    w_after = wr_q.size();
    repeat (20) @(negedge ACLK);
    @(posedge ACLK);
    check("cut_quiet", 32'(wr_q.size() - w_after), 32'd0);
    check("cut_idle", 32'(busy), 32'd0);
    $display("cut at=%0d reset=%0b writes=%0d", at, use_reset, w_after - b_wr);
  endtask

  vec_t        dim_tab [7];
  logic [31:0] exp2_data [4];
  logic [3:0]  exp2_addr [4];

  initial begin
    int b_wr, nok;
    ARESET = 1'b1; start = 1'b1; abort = 1'b0; dim_n = 3'd2;
    a_rdata = '0; b_rdata = '0;
    fill_random();

    // Reset held three cycles with start high.
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      check("reset_strobes", 32'({busy, a_rd_en, b_rd_en, c_wr_en, done, err, irq}), 32'd0);
      check("reset_count", cycle_count, 32'd0);
    end
    ARESET = 1'b0; start = 1'b0;
    @(negedge ACLK);
    check("post_reset_busy", 32'(busy), 32'd0);

    // Worked 2x2 example with fixed expected writes.
    exp2_addr[0] = 4'd0; exp2_addr[1] = 4'd1; exp2_addr[2] = 4'd4; exp2_addr[3] = 4'd5;
    exp2_data[0] = 32'd19; exp2_data[1] = 32'd22; exp2_data[2] = 32'd43; exp2_data[3] = 32'd50;
    a_mem[0] = 16'd1; a_mem[1] = 16'd2; a_mem[4] = 16'd3; a_mem[5] = 16'd4;
    b_mem[0] = 16'd5; b_mem[1] = 16'd6; b_mem[4] = 16'd7; b_mem[5] = 16'd8;
    b_wr = wr_q.size();
    run_job(2, 1'b1, 20, -1);
    for (int e = 0; e < 4 && b_wr + e < wr_q.size(); e++) begin
      check("ex2_addr", 32'(wr_q[b_wr+e].addr), 32'(exp2_addr[e]));
      check("ex2_data", wr_q[b_wr+e].data, exp2_data[e]);
    end

    // Identity times ramp, with a stray start mid-job.
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        a_mem[r*MD+c] = (r == c) ? 16'd1 : 16'd0;
        b_mem[r*MD+c] = 16'(4*r + c);
      end
    b_wr = wr_q.size();
    run_job(4, 1'b1, 112, 20);
    nok = 0;
    for (int e = b_wr; e < wr_q.size(); e++)
      if (wr_q[e].data == 32'(b_mem[wr_q[e].addr])) nok++;
    check("identity_c_eq_b", 32'(nok), 32'd16);

    // Dimension table: invalid values set err without touching memory; valid ones clear it.
    dim_tab[0] = '{dim: 0, exp_ok: 1'b0, exp_busy: 0};
    dim_tab[1] = '{dim: 5, exp_ok: 1'b0, exp_busy: 0};
    dim_tab[2] = '{dim: 1, exp_ok: 1'b1, exp_busy: 4};
    dim_tab[3] = '{dim: 7, exp_ok: 1'b0, exp_busy: 0};
    dim_tab[4] = '{dim: 3, exp_ok: 1'b1, exp_busy: 54};
    dim_tab[5] = '{dim: 6, exp_ok: 1'b0, exp_busy: 0};
    dim_tab[6] = '{dim: 2, exp_ok: 1'b1, exp_busy: 20};
    for (int t = 0; t < 7; t++) begin
      fill_random();
      run_job(dim_tab[t].dim, dim_tab[t].exp_ok, dim_tab[t].exp_busy, -1);
    end

    // start together with abort in IDLE is dropped; abort alone in IDLE is a no-op.
    @(negedge ACLK);
    start = 1'b1; abort = 1'b1; dim_n = 3'd2;
    @(negedge ACLK);
    start = 1'b0; abort = 1'b0;
    check("start_abort_drop", 32'(busy), 32'd0);
    check("abort_idle_done", 32'(done), 32'd1);

    // Abort on busy cycle 10, ARESET on busy cycle 30, then a clean run.
    fill_random();
    cut_job(10, 1'b0);
    cut_job(30, 1'b1);
    fill_random();
    run_job(4, 1'b1, 112, -1);

    // Saturated operands: each element wraps to 4*0xFFFE0001 mod 2^32.
    for (int x = 0; x < MD*MD; x++) begin
      a_mem[x] = 16'hFFFF;
      b_mem[x] = 16'hFFFF;
    end
    b_wr = wr_q.size();
    run_job(4, 1'b1, 112, -1);
    nok = 0;
    for (int e = b_wr; e < wr_q.size(); e++)
      if (wr_q[e].data == 32'hFFF80004) nok++;
    check("all_ffff", 32'(nok), 32'd16);

    // Randomized dimensions and operands against the model.
    repeat (5) begin
      int n;
      n = int'($urandom_range(1, 4));
      fill_random();
      run_job(n, 1'b1, n*n*(n+3), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
